regfile_wb_arbiter: RTL

Write-port controller for the 32x32 integer register file. It shares the file's single write port between two requesters:
- **Port A**: the main pipeline writeback, single-cycle results.
- **Port B**: the long-latency unit (load/mul/div), multi-cycle results.

Arbitration is fixed-priority to A with a starvation guard for B. The block registers the winning write onto the file's `W_en`/`Rd`/`Wr_data` inputs and flags read-after-write hazards to issue logic.

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: fixed priority to the pipeline (A) with a
// starvation guard for the long-latency unit (B). Define REGARB_SCOREBOARD_EN to add the busy scoreboard.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        W_en,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             wEn_q, wEn_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wrData_q, wrData_d;
    logic             starve, grantA, grantB;
    logic             pend1, pend2;

    assign starve  = (starveCnt_q >= LIMIT);
    assign b_ready = ~a_valid | starve;
    assign a_ready = ~(b_valid & starve);
    assign grantB  = b_valid & b_ready;
    assign grantA  = a_valid & ~grantB;

    // The count only survives while B keeps asking and keeps losing; it parks at the limit.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!b_valid || grantB) begin
            starveCnt_d = '0;
        end else if (starveCnt_q < LIMIT) begin
            starveCnt_d = starveCnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        wEn_d    = 1'b0;
        rd_d     = rd_q;
        wrData_d = wrData_q;
        if (grantB) begin
            wEn_d    = |b_rd;
            rd_d     = b_rd;
            wrData_d = b_data;
        end else if (grantA) begin
            wEn_d    = |a_rd;
            rd_d     = a_rd;
            wrData_d = a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt_q <= '0;
            wEn_q       <= 1'b0;
            rd_q        <= '0;
            wrData_q    <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            wEn_q       <= wEn_d;
            rd_q        <= rd_d;
            wrData_q    <= wrData_d;
        end
    end

    assign W_en    = wEn_q;
    assign Rd      = rd_q;
    assign Wr_data = wrData_q;

    // The file only absorbs the write at the end of the W_en cycle, so a reader then sees old data.
    assign pend1 = wEn_q & (rd_q == rs1) & (|rs1);
    assign pend2 = wEn_q & (rd_q == rs2) & (|rs2);

`ifdef REGARB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (grantB) begin
            busy_d[b_rd] = 1'b0;
        end
        if (issue_valid & issue_ready & (|issue_rd)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign issue_ready = ~busy_q[issue_rd];
    assign hazard1     = pend1 | busy_q[rs1];
    assign hazard2     = pend2 | busy_q[rs2];
`else
    logic unusedIssue;

    assign unusedIssue = ^{issue_valid, issue_rd};
    assign issue_ready = 1'b1;
    assign hazard1     = pend1;
    assign hazard2     = pend2;
`endif

endmodule
